// File: rtl/string_match_request_serializer.sv
// Host-side front end for the string-matching processor: streams a latched needle
// (MSB byte first) followed by an upstream haystack, then captures the match result.
module string_match_request_serializer #(
  parameter int STRING_SIZE = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     start,
  input  logic [STRING_SIZE*8-1:0] needle_in,
  input  logic [7:0]               src_data,
  input  logic                     src_valid,
  input  logic                     src_last,
  output logic                     src_ready,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic [7:0]               result_data,
  input  logic                     result_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     match,
  output logic [15:0]              hay_count
);
  localparam int IDX_W  = $clog2(STRING_SIZE + 1);
  localparam int WORD_W = STRING_SIZE * 8;

  typedef enum logic [2:0] {IDLE, NEEDLE, HEYSTACK, WAIT_RESULT, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] needle;
  logic [IDX_W-1:0]  idx;
  logic              vld_p0;
  logic              xfer;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] needle_byte(input logic [WORD_W-1:0] w,
                                             input logic [IDX_W-1:0] k);
    logic [WORD_W-1:0] shifted;
    shifted = w << (8 * k);
    return shifted[WORD_W-1 -: 8];
  endfunction

  assign busy      = (state == NEEDLE) || (state == HEYSTACK) || (state == WAIT_RESULT);
  assign src_ready = enable && (state == HEYSTACK);
  assign xfer      = src_valid && src_ready;
  // A frozen cycle must never present a byte, so the registered valid is masked by enable.
  assign out_valid = vld_p0 && enable;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      needle    <= '0;
      idx       <= '0;
      vld_p0    <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      match     <= 1'b0;
      hay_count <= '0;
    end else if (enable) begin
      unique case (state)
        IDLE, DONE: begin
          vld_p0   <= 1'b0;
          out_last <= 1'b0;
          if (start) begin
            needle    <= needle_in;
            done      <= 1'b0;
            match     <= 1'b0;
            hay_count <= '0;
            out_data  <= needle_byte(needle_in, '0);
            vld_p0    <= 1'b1;
            idx       <= IDX_W'(1);
            state     <= NEEDLE;
          end
        end
        NEEDLE: begin
          out_last <= 1'b0;
          if (idx == IDX_W'(STRING_SIZE)) begin
            vld_p0 <= 1'b0;
            state  <= HEYSTACK;
          end else begin
            out_data <= needle_byte(needle, idx);
            vld_p0   <= 1'b1;
            idx      <= idx + 1'b1;
          end
        end
        HEYSTACK: begin
          vld_p0   <= xfer;
          out_last <= xfer && src_last;
          if (xfer) begin
            out_data  <= src_data;
            hay_count <= sat_inc(hay_count);
            if (src_last) state <= WAIT_RESULT;
          end
        end
        WAIT_RESULT: begin
          vld_p0   <= 1'b0;
          out_last <= 1'b0;
          if (result_valid) begin
            match <= result_data[0];
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/string_match_request_serializer.md
# string_match_request_serializer

Host-side front end for the string-matching processor. Latches a needle word, then drives the processor's byte-stream input with the needle bytes followed by a haystack streamed from an upstream byte source. It then captures the processor's single-byte result and reports match/done status. Sits between the upstream byte source (e.g. UART RX path) and the processor's `in_*` / `out_*` ports.

## Interface
- `STRING_SIZE`, 5, needle length in bytes (≥1); must equal the processor's `STRING_SIZE`
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  global advance; when low the block freezes
- `start`  in  1  begin a request; sampled only in IDLE/DONE
- `needle_in`  in  STRING_SIZE*8  needle word, latched on accepted `start`
- `src_data`  in  8  haystack byte from upstream
- `src_valid`  in  1  `src_data` valid
- `src_last`  in  1  final haystack byte
- `src_ready`  out  1  block accepts `src_data` this cycle
- `out_data`  out  8  byte to processor `in_data`
- `out_valid`  out  1  to processor `in_valid`
- `out_last`  out  1  to processor `in_last`
- `result_data`  in  8  processor `out_data`
- `result_valid`  in  1  processor `out_valid`
- `busy`  out  1  request in flight (NEEDLE, HEYSTACK, WAIT_RESULT)
- `done`  out  1  result captured; held until next accepted `start`
- `match`  out  1  captured `result_data[0]`
- `hay_count`  out  16  haystack bytes forwarded in current request, saturating at 65535

## Operation
- States: IDLE, NEEDLE, HEYSTACK, WAIT_RESULT, DONE.
- IDLE/DONE + `start` & `enable`:
  - latch `needle_in`
  - clear `done`, `match`, `hay_count`
  - reset the byte index
  - go to NEEDLE
- NEEDLE:
  - emit one needle byte per enabled cycle, most-significant byte first: byte k = `needle[(STRING_SIZE-k)*8-1 -: 8]`, k = 0..STRING_SIZE-1
  - `out_last`=0
  - after byte STRING_SIZE-1 is issued, go to HEYSTACK
  - index counter width $clog2(STRING_SIZE+1)
- HEYSTACK:
  - `src_ready` = `enable` & (state==HEYSTACK), combinational
  - on transfer (`src_valid` & `src_ready`): register `out_data`=`src_data`, `out_valid`=1, `out_last`=`src_last`; increment `hay_count` (saturating)
  - transfer with `src_last` → WAIT_RESULT
  - no transfer → `out_valid`=0 next cycle
- WAIT_RESULT: on `result_valid` & `enable`, set `match`=`result_data[0]` and `done`=1, then go to DONE.
- `result_valid` in any other state: ignored.
- `start` while `busy`: ignored.
- `src_ready`=0 in every state except HEYSTACK.
- Source bytes presented outside HEYSTACK are not consumed.
- `enable`=0:
  - no state, counter or register changes
  - `out_valid` driven 0 for that cycle
  - `src_ready`=0
  - `result_valid` ignored
- The processor has no backpressure, so the block never stalls the output except via `enable` or an empty source.

## Timing
- Reset values:
  - state IDLE
  - `out_data`=0, `out_valid`=0, `out_last`=0
  - `src_ready`=0, `busy`=0, `done`=0, `match`=0, `hay_count`=0
  - needle register 0
- `out_*` are registered.
- `start` accepted at cycle t:
  - needle byte 0 appears with `out_valid`=1 at t+1
  - byte STRING_SIZE-1 appears at t+STRING_SIZE
  - `src_ready` first high at t+STRING_SIZE+1
- Haystack latency: a source transfer at cycle h appears on `out_*` at h+1.
- Back-to-back transfers give one output byte per cycle.
- `busy` is combinational from state. It rises the cycle after the accepted `start` and falls the cycle after `result_valid` is captured.
- `done` and `match` update the cycle after the `result_valid` capture.
- `start` in DONE in the same cycle as a stale `result_valid` → `start` wins; the result is ignored.
- Reset mid-request: the next cycle is IDLE with all outputs at reset values; no trailing `out_last` is emitted.

## Test plan
- STRING_SIZE=5, `needle_in`="hello" (0x68656C6C6F), `start` at t=0, source streams "ohello!" contiguously with `src_last` on '!'.
  - `out_data`: 68,65,6C,6C,6F at t=1..5, then 6F,68,65,6C,6C,6F,21 at t=7..13
  - `out_last` only at t=13; `hay_count`=7
  - `result_valid`=1, `result_data`=0x01 at t=20 → `match`=1, `done`=1 at t=21, `busy`=0
- Source gaps: `src_valid` low on alternate cycles. `out_valid` mirrors the gaps one cycle later; byte order is preserved; no duplicates.
- `enable` toggled low for 3 cycles mid-NEEDLE and mid-HEYSTACK.
  - `out_valid`=0 and `src_ready`=0 during the low cycles
  - sequence resumes at the same byte index; final stream is identical to the enable-always case
- Ignored events: `start` pulsed during HEYSTACK, and `result_valid`=1 with `result_data`=0x01 during NEEDLE. Neither changes state; a later real result of 0x00 gives `match`=0, `done`=1.
- Reset in HEYSTACK after 2 haystack bytes: next cycle `out_valid`=0, `busy`=0, `hay_count`=0, state IDLE. A fresh `start` then replays the full needle.
- Single-byte haystack with `src_last` on the first byte: `out_last`=1 on the first haystack output byte, `hay_count`=1, then WAIT_RESULT.
